// File: rtl/spi_mode_master.sv
// SPI master, all four CPOL/CPHA modes, 8-bit MSB-first transfers framed by cs.
// Optional receive path (miso/rx_data) enabled by defining SPI_MODE_MASTER_MISO_EN.
module spi_mode_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] din,
`ifdef SPI_MODE_MASTER_MISO_EN
    input  logic       miso,
    output logic [7:0] rx_data,
`endif
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = 8;
    localparam int unsigned HW = 4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(15);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [HW-1:0] half, half_nx;
    logic          cnt_end;
    logic          load_c;
    logic          fin_c, fin;
    logic          cpol_q, cpha_q;
    logic [7:0]    din_q;
    logic [2:0]    bsel_c;
    logic          sclk_c, mosi_c, cs_c, busy_c;

    assign cnt_end = (cnt == CNT_LAST);

    // Next-state and counter sequencing; fin_c marks the HOLD exit edge.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        half_nx  = half;
        load_c   = 1'b0;
        fin_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                    cnt_nx   = '0;
                    half_nx  = '0;
                    load_c   = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_end) begin
                    cnt_nx   = '0;
                    state_nx = XFER;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            XFER: begin
                if (cnt_end) begin
                    cnt_nx = '0;
                    if (half == HALF_LAST) begin
                        state_nx = HOLD;
                    end else begin
                        half_nx = half + HW'(1);
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_end) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    fin_c    = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Line levels for the current state; registered on the next edge.
    // CPHA=1 shifts the bit schedule by one half-period (bit k on leading edge 2k+1).
    always_comb begin
        cs_c   = 1'b1;
        busy_c = 1'b0;
        sclk_c = cpol_q;
        mosi_c = 1'b0;
        bsel_c = cpha_q ? 3'((half - HW'(1)) >> 1) : half[3:1];
        case (state)
            IDLE: begin
                sclk_c = mode[1];
            end
            SETUP: begin
                cs_c   = 1'b0;
                busy_c = 1'b1;
                mosi_c = cpha_q ? 1'b0 : din_q[7];
            end
            XFER: begin
                cs_c   = 1'b0;
                busy_c = 1'b1;
                sclk_c = cpol_q ^ half[0];
                if (!cpha_q || (half != '0)) begin
                    mosi_c = din_q[~bsel_c];
                end
            end
            HOLD: begin
                cs_c   = 1'b0;
                busy_c = 1'b1;
                mosi_c = din_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            half   <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            din_q  <= '0;
            fin    <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            cs     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            half  <= half_nx;
            if (load_c) begin
                din_q  <= din;
                cpol_q <= mode[1];
                cpha_q <= mode[0];
            end
            fin  <= fin_c;
            done <= fin;
            sclk <= sclk_c;
            mosi <= mosi_c;
            cs   <= cs_c;
            busy <= busy_c;
        end
    end

`ifdef SPI_MODE_MASTER_MISO_EN
    logic [7:0] rx_sr;
    logic       samp_c;

    // Sampling edges: odd edges (leading) for CPHA=0, even edges (trailing) for CPHA=1.
    assign samp_c = (cnt == '0) &&
                    (((state == XFER) && (half != '0) && (half[0] != cpha_q)) ||
                     ((state == HOLD) && cpha_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr   <= '0;
            rx_data <= '0;
        end else begin
            if (load_c) begin
                rx_sr <= '0;
            end else if (samp_c) begin
                rx_sr <= {rx_sr[6:0], miso};
            end
            if (fin) begin
                rx_data <= rx_sr;
            end
        end
    end
`endif

endmodule

// File: doc/spi_mode_master.md
SPI_MODE_MASTER -- requirements
Module: spi_mode_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal values 2..255.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: transfer request, sampled in IDLE only.
REQ-005 SHALL have port mode, input, 2 bits: SPI mode; mode[1]=CPOL, mode[0]=CPHA.
REQ-006 SHALL have port din, input, 8 bits: byte to transmit, MSB first.
REQ-007 SHALL have port sclk, output, 1 bit: serial clock, registered.
REQ-008 SHALL have port mosi, output, 1 bit: serial data out, registered.
REQ-009 SHALL have port cs, output, 1 bit: chip select, active-low, registered.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-clk pulse at transfer end.

Function
REQ-012 SHALL implement states IDLE, SETUP, XFER, HOLD.
REQ-013 IDLE: cs=1, mosi=0, busy=0; sclk registered from mode[1] every cycle, so the idle level tracks CPOL.
REQ-014 IDLE with start=1 at a rising edge: latch din and mode, then go to SETUP; start has no effect in any other state.
REQ-015 SETUP: cs=0 for exactly CLK_DIV cycles; if latched CPHA=0, mosi=din[7] from the first SETUP cycle.
REQ-016 XFER: 16 half-periods of CLK_DIV cycles each; sclk toggles at the end of each half-period (leading edges 1,3,..15; trailing edges 2,4,..16).
REQ-017 CPHA=0: mosi updates to the next bit on trailing edges 2..14 and is held after edge 16, so data is stable at every leading edge.
REQ-018 CPHA=1: mosi takes bit 7-k on leading edge 2k+1 (k=0..7), so data is stable at every trailing edge.
REQ-019 After edge 16, sclk SHALL equal the latched CPOL; go to HOLD.
REQ-020 HOLD: cs=0 and sclk=CPOL for CLK_DIV cycles.
REQ-021 On the HOLD exit edge: cs=1, mosi=0, done=1 for one cycle, state=IDLE.
REQ-022 done rises exactly 18*CLK_DIV+1 clk cycles after the edge that sampled start.
REQ-023 start high in the same cycle done is high SHALL be accepted, giving back-to-back transfers with cs high for at least one cycle.
REQ-024 Changes to mode or din while busy SHALL NOT affect the transfer in progress.
REQ-025 Exactly 8 bits per transfer; the bit counter SHALL NOT wrap within a transfer.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE with cs=1, sclk=0, mosi=0, busy=0, done=0, and clear the latched din, mode and counters, including mid-transfer.
REQ-027 A transfer aborted by reset SHALL NOT produce done.

Configuration
REQ-028 Macro SPI_MODE_MASTER_MISO_EN defined: the block SHALL add input miso (1 bit) and output rx_data (8 bits, reset 0), register miso MSB first on each sampling edge (leading if CPHA=0, trailing if CPHA=1), and update rx_data in the same cycle done is asserted.
REQ-029 Macro undefined: miso and rx_data SHALL be absent and no receive logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 CLK_DIV=4, mode=0, din=8'hA5, start pulse -> cs low, 8 rising sclk edges with mosi 1,0,1,0,0,1,0,1, sclk idles 0, done 73 cycles after start.
REQ-031 mode=3, din=8'h3C -> sclk idles 1, mosi stable at each rising edge with bits 0,0,1,1,1,1,0,0, done once.
REQ-032 mode=1 and mode=2, din=8'hF0 -> data stable at each falling edge; a slave sampling on the falling edge receives 8'hF0.
REQ-033 rst asserted at the 5th sclk edge -> next cycle cs=1, sclk=0, busy=0; no done; a following start with din=8'h81 completes correctly.
REQ-034 start held high across done, din changed to 8'h5A mid-transfer -> first byte unaffected, second transfer sends 8'h5A, cs high for at least one cycle between bytes.
REQ-035 MISO_EN defined, miso looped to mosi, din=8'hC3 in all four modes -> rx_data=8'hC3 in the done cycle.
